// File: rtl/jtkicker_obj_pkg.sv
// Shared definitions for the Kicker object RAM and per-line sprite scanner.
package jtkicker_obj_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        CHK  = 3'd3,
        WAIT = 3'd4,
        NEXT = 3'd5
    } obj_state_t;

    // Byte offsets inside a 2-byte entry: bank 1 holds attr/code, bank 2 holds x/y
    localparam logic ATTR_OFS = 1'b0;
    localparam logic CODE_OFS = 1'b1;
    localparam logic X_OFS    = 1'b0;
    localparam logic Y_OFS    = 1'b1;

    localparam logic [7:0] OBJ_H = 8'd16;

    function automatic logic [7:0] cond_inv(input logic inv, input logic [7:0] val);
        return inv ? ~val : val;
    endfunction

endpackage

// File: rtl/jtkicker_obj_dpram.sv
// Byte-wide dual-port RAM: port A is the CPU read/write side, port B the scanner read side.
// Both ports register their read data and return the pre-write contents on a collision.
module jtkicker_obj_dpram #(
    parameter int AW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_a_en,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [7:0]    i_a_din,
    output logic [7:0]    o_a_dout,
    input  logic [AW-1:0] i_b_addr,
    output logic [7:0]    o_b_dout
);

    logic [7:0] r_mem [0:(2**AW)-1];

    // Storage write; contents are deliberately left unreset
    always_ff @(posedge i_clk) begin
        if (i_a_we) begin
            r_mem[i_a_addr] <= i_a_din;
        end
    end

    // Registered reads; port A keeps its last word while not enabled
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_a_dout <= 8'd0;
            o_b_dout <= 8'd0;
        end else begin
            if (i_a_en) begin
                o_a_dout <= r_mem[i_a_addr];
            end
            o_b_dout <= r_mem[i_b_addr];
        end
    end

endmodule

// File: rtl/jtkicker_obj_scan.sv
// Object RAM CPU responder plus a per-scanline sprite scanner that feeds the draw engine
// every entry whose 16-line band contains the line about to be rendered.
module jtkicker_obj_scan
    import jtkicker_obj_pkg::*;
#(
    parameter int AW         = 10,
    parameter int NOBJ       = 24,
    parameter int OBJ_OFFSET = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_cen,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    input  logic          cpu_rnw,
    input  logic          obj1_cs,
    input  logic          obj2_cs,
    output logic [7:0]    obj_dout,
    input  logic          hs,
    input  logic [7:0]    vrender,
    input  logic          flip,
    output logic          dr_start,
    input  logic          dr_busy,
    output logic [7:0]    dr_code,
    output logic [7:0]    dr_attr,
    output logic [7:0]    dr_xpos,
    output logic [3:0]    dr_v,
    output logic          scan_done
);

    obj_state_t    r_state, w_nxt_state;
    logic [6:0]    r_idx;
    logic          r_hs_l, r_sel1;
    logic [7:0]    r_attr, r_x, r_code;
    logic [3:0]    r_ydf;
    logic          w_cpu_we, w_hs_edge, w_odd, w_hit;
    logic          w_idx_clr, w_idx_inc, w_load, w_done_set;
    logic [AW-1:0] w_addr1, w_addr2;
    logic [7:0]    w_q1a, w_q2a, w_q1b, w_q2b, w_yd;
    logic [3:0]    w_ydf;

    assign w_cpu_we  = (obj1_cs | obj2_cs) & ~cpu_rnw & cpu_cen;
    assign w_hs_edge = hs & ~r_hs_l;
    assign w_odd     = (r_state == RD1);
    assign w_addr1   = AW'(OBJ_OFFSET) + AW'({r_idx, w_odd ? CODE_OFS : ATTR_OFS});
    assign w_addr2   = AW'(OBJ_OFFSET) + AW'({r_idx, w_odd ? Y_OFS : X_OFS});
    // Only valid in CHK, when the odd (y) byte is on the bank 2 scan port
    assign w_yd      = vrender - w_q2b;
    assign w_hit     = (w_yd < OBJ_H);
    assign w_ydf     = flip ? ~w_yd[3:0] : w_yd[3:0];
    assign obj_dout  = r_sel1 ? w_q1a : w_q2a;

    jtkicker_obj_dpram #(.AW(AW)) u_bank1 (
        .i_clk(clk), .i_rst(rst),
        .i_a_en(obj1_cs), .i_a_we(w_cpu_we & obj1_cs), .i_a_addr(cpu_addr),
        .i_a_din(cpu_dout), .o_a_dout(w_q1a),
        .i_b_addr(w_addr1), .o_b_dout(w_q1b)
    );

    jtkicker_obj_dpram #(.AW(AW)) u_bank2 (
        .i_clk(clk), .i_rst(rst),
        .i_a_en(obj2_cs), .i_a_we(w_cpu_we & obj2_cs), .i_a_addr(cpu_addr),
        .i_a_din(cpu_dout), .o_a_dout(w_q2a),
        .i_b_addr(w_addr2), .o_b_dout(w_q2b)
    );

    // Remember which bank the last CPU access targeted so obj_dout holds between accesses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel1 <= 1'b0;
        end else if (obj1_cs | obj2_cs) begin
            r_sel1 <= obj1_cs;
        end else begin
            r_sel1 <= r_sel1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next state and datapath strobes; an hs edge overrides everything, including a pending load
    always_comb begin
        w_nxt_state = r_state;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_load      = 1'b0;
        w_done_set  = 1'b0;
        if (w_hs_edge) begin
            w_nxt_state = RD0;
            w_idx_clr   = 1'b1;
        end else begin
            case (r_state)
                IDLE: w_nxt_state = IDLE;
                RD0:  w_nxt_state = RD1;
                RD1:  w_nxt_state = CHK;
                CHK:  w_nxt_state = w_hit ? WAIT : NEXT;
                WAIT: begin
                    if (!dr_busy) begin
                        w_load      = 1'b1;
                        w_nxt_state = NEXT;
                    end else begin
                        w_nxt_state = WAIT;
                    end
                end
                NEXT: begin
                    if (r_idx == 7'(NOBJ - 1)) begin
                        w_done_set  = 1'b1;
                        w_nxt_state = IDLE;
                    end else begin
                        w_idx_inc   = 1'b1;
                        w_nxt_state = RD0;
                    end
                end
                default: w_nxt_state = IDLE;
            endcase
        end
    end

    // Scan datapath: index, edge detector, entry capture and draw request outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= 7'd0;
            r_hs_l    <= 1'b0;
            r_attr    <= 8'd0;
            r_x       <= 8'd0;
            r_code    <= 8'd0;
            r_ydf     <= 4'd0;
            dr_start  <= 1'b0;
            dr_code   <= 8'd0;
            dr_attr   <= 8'd0;
            dr_xpos   <= 8'd0;
            dr_v      <= 4'd0;
            scan_done <= 1'b0;
        end else begin
            r_hs_l   <= hs;
            dr_start <= w_load;
            if (w_idx_clr) begin
                r_idx <= 7'd0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 7'd1;
            end
            if (r_state == RD1) begin
                r_attr <= w_q1b;
                r_x    <= w_q2b;
            end
            if (r_state == CHK) begin
                r_code <= w_q1b;
                r_ydf  <= w_ydf;
            end
            if (w_load) begin
                dr_code <= r_code;
                dr_attr <= r_attr;
                dr_xpos <= cond_inv(flip, r_x);
                dr_v    <= r_ydf;
            end
            if (w_hs_edge) begin
                scan_done <= 1'b0;
            end else if (w_done_set) begin
                scan_done <= 1'b1;
            end
        end
    end

endmodule
